// File: rtl/corefifo_fwft_rd_pkg.sv
// Shared types and helpers for the FWFT line reader.
package corefifo_fwft_rd_pkg;

    localparam int unsigned UNDERRUN_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } rd_state_t;

    // Word counter width for a given line length (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

    // Drive level of the FIFO read enable for a given pop request.
    function automatic logic rd_en_level(input logic pop, input bit read_low);
        return read_low ? ~pop : pop;
    endfunction

endpackage

// File: rtl/corefifo_fwft_line_reader.sv
// Pops one line of FWFT words per request and re-emits them as a framed valid/ready stream.
// Optional underrun counter enabled by defining FWFT_RD_UNDERRUN_EN.
module corefifo_fwft_line_reader
    import corefifo_fwft_rd_pkg::*;
#(
    parameter int unsigned RWIDTH   = 16,
    parameter int unsigned LINE_LEN = 640,
    parameter int unsigned CNT_W    = cnt_width(LINE_LEN),
    parameter bit          READ_LOW = 1'b1
) (
    input  logic              pos_rclk,
    input  logic              aresetn_rclk,
    input  logic              sresetn_rclk,
    input  logic              line_req,
    input  logic              abort,
    input  logic              fwft_empty,
    input  logic [RWIDTH-1:0] fwft_dout,
    output logic              fwft_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [RWIDTH-1:0] m_data,
    output logic              m_sol,
    output logic              m_eol,
    output logic              busy,
    output logic              line_done
`ifdef FWFT_RD_UNDERRUN_EN
    ,
    output logic [UNDERRUN_W-1:0] underrun_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_LEN - 1);

    rd_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             slot_free;
    logic             pop;

    // Pop is suppressed during sync reset and abort so the FIFO head is never lost.
    assign slot_free  = !m_valid || m_ready;
    assign pop        = (state == STREAM) && !fwft_empty && slot_free && sresetn_rclk && !abort;
    assign fwft_rd_en = rd_en_level(pop, READ_LOW);
    assign busy       = (state != IDLE);

    // FSM, word counter and output register.
    always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
        if (!aresetn_rclk) begin
            state     <= IDLE;
            cnt       <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_sol     <= 1'b0;
            m_eol     <= 1'b0;
            line_done <= 1'b0;
        end else if (!sresetn_rclk) begin
            state     <= IDLE;
            cnt       <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_sol     <= 1'b0;
            m_eol     <= 1'b0;
            line_done <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            cnt       <= '0;
            m_valid   <= 1'b0;
            line_done <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (pop) begin
                m_data  <= fwft_dout;
                m_valid <= 1'b1;
                m_sol   <= (cnt == '0);
                m_eol   <= (cnt == LAST);
                cnt     <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (line_req) begin
                        state <= STREAM;
                        cnt   <= '0;
                    end
                end
                STREAM: begin
                    if (pop && (cnt == LAST)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_valid && m_ready && m_eol) begin
                        state     <= IDLE;
                        line_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FWFT_RD_UNDERRUN_EN
    // Cycles where the sink could take a word but the FIFO had none; saturating.
    always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
        if (!aresetn_rclk) begin
            underrun_cnt <= '0;
        end else if (!sresetn_rclk) begin
            underrun_cnt <= '0;
        end else if ((state == STREAM) && slot_free && fwft_empty && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_corefifo_fwft_line_reader.sv
// Directed bench for corefifo_fwft_line_reader with LINE_LEN=4, RWIDTH=16, READ_LOW=1.
module tb_corefifo_fwft_line_reader;

    logic        pos_rclk = 1'b0;
    logic        aresetn_rclk, sresetn_rclk, line_req, abort, m_ready;
    logic        fwft_empty, fwft_rd_en, m_valid, m_sol, m_eol, busy, line_done;
    logic [15:0] fwft_dout, m_data;
`ifdef FWFT_RD_UNDERRUN_EN
    logic [15:0] underrun_cnt;
`endif

    logic [15:0] mem [0:31];
    int          rd_ptr = 0;
    int          wr_ptr = 0;
    logic        hold_empty = 1'b0;
    int          cyc = 0;

    logic [15:0] cap_data [0:255];
    logic        cap_sol  [0:255];
    logic        cap_eol  [0:255];
    int          cap_total = 0;
    int          pop_cyc  [0:255];
    int          pop_total = 0;
    int          pop_empty_errs = 0;
    int          done_total = 0;
    int          last_eol_cyc = 0;
    int          last_done_cyc = 0;

    int n_cmp = 0;
    int n_fail = 0;

    corefifo_fwft_line_reader #(
        .RWIDTH   (16),
        .LINE_LEN (4),
        .READ_LOW (1'b1)
    ) dut (
        .pos_rclk     (pos_rclk),
        .aresetn_rclk (aresetn_rclk),
        .sresetn_rclk (sresetn_rclk),
        .line_req     (line_req),
        .abort        (abort),
        .fwft_empty   (fwft_empty),
        .fwft_dout    (fwft_dout),
        .fwft_rd_en   (fwft_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_sol        (m_sol),
        .m_eol        (m_eol),
        .busy         (busy),
        .line_done    (line_done)
`ifdef FWFT_RD_UNDERRUN_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 pos_rclk = ~pos_rclk;

    // Show-ahead FIFO model: head is always visible, pop advances on the clock edge.
    assign fwft_empty = hold_empty || (rd_ptr == wr_ptr);
    assign fwft_dout  = mem[rd_ptr % 32];

    always @(posedge pos_rclk) begin
        cyc <= cyc + 1;
        if (fwft_rd_en === 1'b0) rd_ptr <= rd_ptr + 1;
    end

    // Stream and pop monitor, sampled mid-cycle.
    always @(negedge pos_rclk) begin
        if (m_valid && m_ready) begin
            cap_data[cap_total % 256] <= m_data;
            cap_sol[cap_total % 256]  <= m_sol;
            cap_eol[cap_total % 256]  <= m_eol;
            cap_total <= cap_total + 1;
            if (m_eol) last_eol_cyc <= cyc;
        end
        if (fwft_rd_en === 1'b0) begin
            pop_cyc[pop_total % 256] <= cyc;
            pop_total <= pop_total + 1;
            if (fwft_empty) pop_empty_errs <= pop_empty_errs + 1;
        end
        if (line_done) begin
            done_total <= done_total + 1;
            last_done_cyc <= cyc;
        end
    end

    task automatic tick();
        @(posedge pos_rclk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        mem[wr_ptr % 32] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic load(input int n);
        wr_ptr = rd_ptr;
        for (int i = 0; i < n; i++) push(16'(16'h10 + i));
    endtask

    task automatic pulse_req();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
    endtask

    task automatic wait_val(input logic [15:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (m_valid && (m_data == v)) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (done_total > base) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        aresetn_rclk = 1'b0;
        load(4);
        tick();
        tick();
        n_cmp++; if (fwft_rd_en !== 1'b1) begin n_fail++; $display("FAIL reset_rd_en got %b want 1", fwft_rd_en); end
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (m_data !== 16'h0000) begin n_fail++; $display("FAIL reset_m_data got %h want 0000", m_data); end
        aresetn_rclk = 1'b1;
        tick();
        n_cmp++; if (fwft_rd_en !== 1'b1) begin n_fail++; $display("FAIL idle_rd_en got %b want 1", fwft_rd_en); end
    endtask

    task automatic test_basic_line();
        int cb, pb, db;
        bit ok;
        load(5);
        cb = cap_total; pb = pop_total; db = done_total;
        m_ready = 1'b1;
        pulse_req();
        wait_done(db, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got no line_done want one"); end
        tick();
        tick();
        n_cmp++; if (cap_total - cb !== 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", cap_total - cb); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (cap_data[cb + i] !== 16'(16'h10 + i) || cap_sol[cb + i] !== (i == 0) || cap_eol[cb + i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL basic_word%0d got %h sol=%b eol=%b want %h sol=%b eol=%b", i,
                         cap_data[cb + i], cap_sol[cb + i], cap_eol[cb + i], 16'(16'h10 + i), i == 0, i == 3);
            end
        end
        n_cmp++; if (pop_total - pb !== 4) begin n_fail++; $display("FAIL basic_pops got %0d want 4", pop_total - pb); end
        n_cmp++; if (pop_cyc[pb + 3] - pop_cyc[pb] !== 3) begin n_fail++; $display("FAIL basic_pop_span got %0d want 3", pop_cyc[pb + 3] - pop_cyc[pb]); end
        n_cmp++; if (last_done_cyc - last_eol_cyc !== 1) begin n_fail++; $display("FAIL basic_done_lag got %0d want 1", last_done_cyc - last_eol_cyc); end
        n_cmp++; if (done_total - db !== 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d want 1", done_total - db); end
        n_cmp++; if (fwft_empty !== 1'b0 || fwft_dout !== 16'h0014) begin n_fail++; $display("FAIL basic_fifth_word got empty=%b head=%h want 0/0014", fwft_empty, fwft_dout); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
    endtask

    task automatic test_ready_stall();
        int cb, db;
        bit ok;
        load(4);
        cb = cap_total; db = done_total;
        m_ready = 1'b1;
        pulse_req();
        wait_val(16'h0011, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL stall_reach got no 0011 want 0011"); end
        m_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (m_data !== 16'h0011 || m_valid !== 1'b1 || fwft_rd_en !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d got data=%h valid=%b rd_en=%b want 0011/1/1", i, m_data, m_valid, fwft_rd_en);
            end
            tick();
        end
        m_ready = 1'b1;
        wait_done(db, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL stall_timeout got no line_done want one"); end
        tick();
        n_cmp++; if (cap_total - cb !== 4) begin n_fail++; $display("FAIL stall_count got %0d want 4", cap_total - cb); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (cap_data[cb + i] !== 16'(16'h10 + i) || cap_sol[cb + i] !== (i == 0) || cap_eol[cb + i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL stall_word%0d got %h sol=%b eol=%b want %h", i, cap_data[cb + i], cap_sol[cb + i], cap_eol[cb + i], 16'(16'h10 + i));
            end
        end
    endtask

    task automatic test_empty_stall();
        int cb, db;
        bit ok;
`ifdef FWFT_RD_UNDERRUN_EN
        logic [15:0] ur0;
`endif
        load(4);
        cb = cap_total; db = done_total;
        m_ready = 1'b1;
        pulse_req();
        wait_val(16'h0012, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL empty_reach got no 0012 want 0012"); end
`ifdef FWFT_RD_UNDERRUN_EN
        ur0 = underrun_cnt;
`endif
        hold_empty = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (fwft_rd_en !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL empty_hold%0d got rd_en=%b busy=%b want 1/1", i, fwft_rd_en, busy);
            end
            tick();
        end
        hold_empty = 1'b0;
`ifdef FWFT_RD_UNDERRUN_EN
        n_cmp++; if (16'(underrun_cnt - ur0) !== 16'd5) begin n_fail++; $display("FAIL underrun_delta got %0d want 5", 16'(underrun_cnt - ur0)); end
`endif
        wait_done(db, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL empty_timeout got no line_done want one"); end
        tick();
        n_cmp++; if (cap_total - cb !== 4) begin n_fail++; $display("FAIL empty_count got %0d want 4", cap_total - cb); end
        n_cmp++;
        if (cap_data[cb + 2] !== 16'h0012 || cap_data[cb + 3] !== 16'h0013 || cap_eol[cb + 3] !== 1'b1 || cap_eol[cb + 2] !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_tail got %h,%h eol=%b want 0012,0013 eol=1", cap_data[cb + 2], cap_data[cb + 3], cap_eol[cb + 3]);
        end
    endtask

    task automatic test_req_during_stream();
        int cb, db;
        bit ok;
        load(8);
        cb = cap_total; db = done_total;
        m_ready = 1'b1;
        pulse_req();
        wait_val(16'h0011, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL busyreq_reach got no 0011 want 0011"); end
        pulse_req();
        wait_done(db, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL busyreq_timeout got no line_done want one"); end
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (cap_total - cb !== 4) begin n_fail++; $display("FAIL busyreq_count got %0d want 4", cap_total - cb); end
        n_cmp++; if (done_total - db !== 1) begin n_fail++; $display("FAIL busyreq_lines got %0d want 1", done_total - db); end
        n_cmp++; if (busy !== 1'b0 || fwft_dout !== 16'h0014) begin n_fail++; $display("FAIL busyreq_state got busy=%b head=%h want 0/0014", busy, fwft_dout); end
    endtask

    task automatic test_abort();
        int cb, db;
        bit ok;
        load(8);
        db = done_total;
        m_ready = 1'b1;
        pulse_req();
        wait_val(16'h0011, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL abort_reach got no 0011 want 0011"); end
        abort = 1'b1;
        #1;
        n_cmp++; if (fwft_rd_en !== 1'b1) begin n_fail++; $display("FAIL abort_nopop got rd_en=%b want 1", fwft_rd_en); end
        tick();
        abort = 1'b0;
        n_cmp++; if (m_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_state got valid=%b busy=%b want 0/0", m_valid, busy); end
        n_cmp++; if (fwft_dout !== 16'h0012) begin n_fail++; $display("FAIL abort_head got %h want 0012", fwft_dout); end
        abort = 1'b1;
        line_req = 1'b1;
        tick();
        abort = 1'b0;
        line_req = 1'b0;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0 || done_total !== db) begin n_fail++; $display("FAIL abort_wins got busy=%b done=%0d want 0/%0d", busy, done_total, db); end
        cb = cap_total;
        pulse_req();
        wait_done(db, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL abort_relaunch_timeout got no line_done want one"); end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (cap_data[cb + i] !== 16'(16'h12 + i) || cap_sol[cb + i] !== (i == 0) || cap_eol[cb + i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL relaunch_word%0d got %h sol=%b eol=%b want %h", i, cap_data[cb + i], cap_sol[cb + i], cap_eol[cb + i], 16'(16'h12 + i));
            end
        end
    endtask

    task automatic test_sync_reset();
        bit ok;
        load(8);
        m_ready = 1'b1;
        pulse_req();
        wait_val(16'h0011, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL srst_reach got no 0011 want 0011"); end
        sresetn_rclk = 1'b0;
        #1;
        n_cmp++; if (fwft_rd_en !== 1'b1) begin n_fail++; $display("FAIL srst_rd_en got %b want 1", fwft_rd_en); end
        tick();
        n_cmp++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 16'h0000 || line_done !== 1'b0) begin
            n_fail++;
            $display("FAIL srst_state got valid=%b busy=%b data=%h done=%b want 0/0/0000/0", m_valid, busy, m_data, line_done);
        end
        sresetn_rclk = 1'b1;
        tick();
    endtask

    initial begin
        aresetn_rclk = 1'b0;
        sresetn_rclk = 1'b1;
        line_req     = 1'b0;
        abort        = 1'b0;
        m_ready      = 1'b1;
        test_reset();
        test_basic_line();
        test_ready_stall();
        test_empty_stall();
        test_req_during_stream();
        test_abort();
        test_sync_reset();
        n_cmp++; if (pop_empty_errs !== 0) begin n_fail++; $display("FAIL pop_on_empty got %0d want 0", pop_empty_errs); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
